rotary_decoder_mc: RTL and testbench
====================================

ROTARY_DECODER_MC -- requirements
Module: rotary_decoder_mc

Interface
REQ-001 Parameter N_CH, default 2: number of independent encoder channels (1..8).
REQ-002 Parameter CNT_W, default 8: position counter width per channel.
REQ-003 Parameter PB_W, default 12: pushbutton press counter width per channel.
REQ-004 Parameter DB_CYC, default 4: debounce stability window in clocks (>=1).
REQ-005 clk  input  1  single clock, rising-edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-007 A  input  N_CH  quadrature phase A per channel, asynchronous pins.
REQ-008 B  input  N_CH  quadrature phase B per channel, asynchronous pins.
REQ-009 PB  input  N_CH  pushbutton per channel, active-high, asynchronous.
REQ-010 mode  input  2  decode resolution: 00 x1, 01 x2, 10 x4, 11 treated as x4.
REQ-011 sat  input  1  1 = saturate counters, 0 = wrap modulo 2^CNT_W.
REQ-012 clr  input  1  synchronous clear of cnt, pb_cnt, err for all channels.
REQ-013 cnt  output  N_CH*CNT_W  unsigned position, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 pb_cnt  output  N_CH*PB_W  press count, same packing rule.
REQ-015 step  output  N_CH  one-cycle pulse when channel cnt changes or would change (incl. clamped).
REQ-016 dir  output  N_CH  direction of last accepted step: 1 up, 0 down.
REQ-017 pb_press  output  N_CH  one-cycle pulse per accepted press.
REQ-018 err  output  N_CH  sticky flag: illegal quadrature transition seen.

Function
REQ-019 Each of A, B, PB per channel SHALL pass a 2-FF synchroniser, then a debouncer that updates its filtered value only after the synchronised value differs from it for DB_CYC consecutive clocks; any bounce restarts the window.
REQ-020 Decode SHALL compare registered previous filtered {A,B} with current; up sequence 00->10->11->01->00, reverse is down.
REQ-021 x4: every legal transition counts; x2: only transitions where A changes; x1: only A rising (B=0 up, B=1 down).
REQ-022 Both A and B changing in one filtered update SHALL produce no count and set err[i].
REQ-023 Wrap mode: cnt wraps max->0 up, 0->max down; sat mode: clamps at max and 0, step still pulses, dir updates.
REQ-024 Latency pin change -> cnt/step update SHALL be exactly DB_CYC+3 clocks for a clean edge.
REQ-025 PB filtered rising edge SHALL increment pb_cnt (always wraps) and pulse pb_press; release does nothing.
REQ-026 clr SHALL override a same-cycle step/press: counters and err go to 0, step and pb_press still pulse, dir still updates.
REQ-027 A mode or sat change SHALL affect only transitions after it; the change itself never counts.
REQ-028 Channels SHALL be fully independent; simultaneous events on all channels all count.

Reset
REQ-029 During rstn low: cnt, pb_cnt, step, dir, pb_press, err, synchronisers and filters all 0.
REQ-030 After release, an arm phase of DB_CYC+2 clocks SHALL load filters with pin levels without producing step, pb_press or err.
REQ-031 Reset asserted mid-debounce or mid-transition SHALL discard it; no event after release is attributed to it.

Structure
REQ-032 Shared package rotary_pkg SHALL hold mode encodings (MODE_X1, MODE_X2, MODE_X4) and the 2-bit quadrature state constants.
REQ-033 One sub-module enc_debounce (synchroniser + DB_CYC filter, one bit) SHALL be instantiated 3*N_CH times.

Verification
REQ-034 Defaults, mode=x4, sat=0, 8 clean up-cycles on ch0 -> cnt0=32, dir0=1, 32 step pulses, each DB_CYC+3=7 clocks after its edge.
REQ-035 mode=x1, cnt0=0, one down-cycle then sat=0 -> cnt0=255; repeat with sat=1 -> cnt0 stays 0, step pulses, dir0=0.
REQ-036 PB bounce 3-clock glitches then stable 20 clocks high on ch1 -> pb_cnt1=1, single pb_press; ch0 unchanged.
REQ-037 Force A and B of ch0 to flip in same cycle, stable -> cnt0 unchanged, err0=1 until clr pulse -> err0=0, cnt0=0.
REQ-038 Pins high at reset release -> no step/pb_press during arm phase; then clr coincident with a step -> cnt=0, step pulses.

Source files
------------

// File: rtl/rotary_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotary_pkg
//  Description : Shared constants and the quadrature transition decoder
//                used by the multi-channel rotary encoder decoder.
//                Quadrature states are written as {A,B}. The forward
//                ("up") sequence is 00 -> 10 -> 11 -> 01 -> 00.
//  Revision    : 1.0 - initial release
// ============================================================================
package rotary_pkg;

    // Decode resolution selected by the mode input. 2'b11 decodes as x4.
    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    // Quadrature states, {A,B}
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    typedef enum logic [1:0] {
        QD_NONE    = 2'd0,
        QD_UP      = 2'd1,
        QD_DOWN    = 2'd2,
        QD_ILLEGAL = 2'd3
    } qdec_e;

    // Classify one filtered transition. Both phases moving at once cannot
    // be attributed to a direction and is reported as illegal.
    function automatic qdec_e quad_decode(input logic [1:0] prev, input logic [1:0] curr);
        qdec_e r;
        r = QD_NONE;
        if (prev != curr) begin
            if ((prev ^ curr) == 2'b11) begin
                r = QD_ILLEGAL;
            end else begin
                case ({prev, curr})
                    {QS_00, QS_10},
                    {QS_10, QS_11},
                    {QS_11, QS_01},
                    {QS_01, QS_00}: r = QD_UP;
                    default:        r = QD_DOWN;
                endcase
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : enc_debounce
//  Description : One-bit 2-FF synchroniser followed by a stability filter.
//                The filtered output takes the synchronised value only after
//                it has differed from the current filtered value for DB_CYC
//                consecutive clocks; any return to the filtered value
//                restarts the window. While load_i is high the filter is
//                loaded directly with the synchronised value.
//  Ports       : clk, rstn  - clock, async active-low reset
//                load_i     - arm phase: load filter without filtering
//                din_i      - asynchronous pin
//                sync_o     - synchronised (unfiltered) value
//                filt_o     - debounced value
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic load_i,
    input  logic din_i,
    output logic sync_o,
    output logic filt_o
);

    localparam int            CW   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYC - 1);

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (load_i) begin
            filt_d = sync_q;
        end else if (sync_q != filt_q) begin
            // The DB_CYC-th consecutive differing sample commits the value.
            if (cnt_q == LAST) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_o = sync_q;
    assign filt_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/rotary_decoder_mc.sv
`default_nettype none
// ============================================================================
//  Module      : rotary_decoder_mc
//  Description : N_CH independent quadrature encoder decoders with
//                pushbutton press counters. Every pin is synchronised and
//                debounced; the decoder compares the previous and current
//                filtered {A,B} to count position in x1/x2/x4 resolution,
//                with wrap or saturate behaviour and a sticky error flag on
//                illegal (double) transitions.
//  Ports       : clk, rstn          - clock, async active-low reset
//                A, B, PB [N_CH]    - encoder phases / pushbuttons (async)
//                mode[1:0], sat     - resolution, saturate enable
//                clr                - sync clear of cnt, pb_cnt, err
//                cnt [N_CH*CNT_W]   - positions, ch i at [i*CNT_W +: CNT_W]
//                pb_cnt [N_CH*PB_W] - press counts, same packing
//                step, dir          - step pulse and last direction (1 = up)
//                pb_press, err      - press pulse, sticky illegal flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rotary_decoder_mc #(
    parameter int N_CH   = 2,
    parameter int CNT_W  = 8,
    parameter int PB_W   = 12,
    parameter int DB_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         A,
    input  logic [N_CH-1:0]         B,
    input  logic [N_CH-1:0]         PB,
    input  logic [1:0]              mode,
    input  logic                    sat,
    input  logic                    clr,
    output logic [N_CH*CNT_W-1:0]   cnt,
    output logic [N_CH*PB_W-1:0]    pb_cnt,
    output logic [N_CH-1:0]         step,
    output logic [N_CH-1:0]         dir,
    output logic [N_CH-1:0]         pb_press,
    output logic [N_CH-1:0]         err
);

    import rotary_pkg::*;

    // Arm phase after reset: filters and previous-state registers follow
    // the pins directly so that static pin levels never look like events.
    localparam int            ARM_LEN = DB_CYC + 2;
    localparam int            AW      = $clog2(ARM_LEN + 1);
    localparam logic [AW-1:0] ARM_END = AW'(ARM_LEN);

    logic [AW-1:0] arm_q;
    logic          arming;

    assign arming = (arm_q != ARM_END);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arm_q <= '0;
        end else if (arming) begin
            arm_q <= arm_q + AW'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             a_s, b_s, pb_s;
        logic             a_f, b_f, pb_f;
        logic [1:0]       ab_prev_q;
        logic             pb_prev_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [PB_W-1:0]  pbc_q, pbc_d;
        logic             step_q, step_d;
        logic             dir_q, dir_d;
        logic             press_q, press_d;
        logic             err_q, err_d;
        qdec_e            dec;
        logic             qual;

        enc_debounce #(.DB_CYC(DB_CYC)) u_db_a (
            .clk(clk), .rstn(rstn), .load_i(arming), .din_i(A[i]),
            .sync_o(a_s), .filt_o(a_f)
        );
        enc_debounce #(.DB_CYC(DB_CYC)) u_db_b (
            .clk(clk), .rstn(rstn), .load_i(arming), .din_i(B[i]),
            .sync_o(b_s), .filt_o(b_f)
        );
        enc_debounce #(.DB_CYC(DB_CYC)) u_db_pb (
            .clk(clk), .rstn(rstn), .load_i(arming), .din_i(PB[i]),
            .sync_o(pb_s), .filt_o(pb_f)
        );

        always_comb begin
            dec = quad_decode(ab_prev_q, {a_f, b_f});
            // Resolution qualifier: x1 counts only A rising, x2 any A edge.
            case (mode)
                MODE_X1: qual = ~ab_prev_q[1] & a_f;
                MODE_X2: qual = ab_prev_q[1] ^ a_f;
                default: qual = 1'b1;
            endcase

            cnt_d   = cnt_q;
            pbc_d   = pbc_q;
            step_d  = 1'b0;
            dir_d   = dir_q;
            press_d = 1'b0;
            err_d   = err_q;

            if (!arming) begin
                if (dec == QD_ILLEGAL) begin
                    err_d = 1'b1;
                end else if ((dec == QD_UP || dec == QD_DOWN) && qual) begin
                    step_d = 1'b1;
                    dir_d  = (dec == QD_UP);
                    // Wrap falls out of modular arithmetic; saturate holds.
                    if (dec == QD_UP) begin
                        if (!(sat && cnt_q == '1)) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        if (!(sat && cnt_q == '0)) cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                if (pb_f && !pb_prev_q) begin
                    press_d = 1'b1;
                    pbc_d   = pbc_q + PB_W'(1);
                end
            end

            // Clear wins over the counters only; pulses and dir still update.
            if (clr) begin
                cnt_d = '0;
                pbc_d = '0;
                err_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ab_prev_q <= 2'b00;
                pb_prev_q <= 1'b0;
                cnt_q     <= '0;
                pbc_q     <= '0;
                step_q    <= 1'b0;
                dir_q     <= 1'b0;
                press_q   <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                // During arm the previous state tracks the synchroniser so it
                // matches the filter value loaded on the same edge.
                if (arming) begin
                    ab_prev_q <= {a_s, b_s};
                    pb_prev_q <= pb_s;
                end else begin
                    ab_prev_q <= {a_f, b_f};
                    pb_prev_q <= pb_f;
                end
                cnt_q   <= cnt_d;
                pbc_q   <= pbc_d;
                step_q  <= step_d;
                dir_q   <= dir_d;
                press_q <= press_d;
                err_q   <= err_d;
            end
        end

        assign cnt[i*CNT_W +: CNT_W]  = cnt_q;
        assign pb_cnt[i*PB_W +: PB_W] = pbc_q;
        assign step[i]                = step_q;
        assign dir[i]                 = dir_q;
        assign pb_press[i]            = press_q;
        assign err[i]                 = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_rotary_decoder_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotary_decoder_mc
//  Description : Scoreboard bench for rotary_decoder_mc. Stimulus tasks push
//                expected step/press events (value, direction, cycle) into a
//                queue; a monitor pops and compares whenever the DUT pulses
//                step or pb_press. Directed checks cover reset, final counts,
//                error flag and clear behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_decoder_mc;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 8;
    localparam int PB_W   = 12;
    localparam int DB_CYC = 4;
    localparam int LAT    = DB_CYC + 3;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [N_CH-1:0]       A, B, PB;
    logic [1:0]            mode;
    logic                  sat;
    logic                  clr;
    logic [N_CH*CNT_W-1:0] cnt;
    logic [N_CH*PB_W-1:0]  pb_cnt;
    logic [N_CH-1:0]       step, dir, pb_press, err;

    rotary_decoder_mc #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PB_W(PB_W), .DB_CYC(DB_CYC)
    ) dut (
        .clk(clk), .rstn(rstn), .A(A), .B(B), .PB(PB), .mode(mode),
        .sat(sat), .clr(clr), .cnt(cnt), .pb_cnt(pb_cnt), .step(step),
        .dir(dir), .pb_press(pb_press), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 step, 1 press
        int ch;
        int val;
        int dir;
        int cyc;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         steps[N_CH];
    int         mcnt[N_CH];
    int         mpb[N_CH];
    logic [1:0] mab[N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_evt(input int kind, input int ch, input int val, input int dv);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_evt: kind=%0d ch=%0d val=%0d at cyc %0d, none expected",
                     kind, ch, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.ch != ch || e.val != val || e.cyc != cyc ||
                (kind == 0 && e.dir != dv)) begin
                errors++;
                $display("FAIL evt: got kind=%0d ch=%0d val=%0d dir=%0d cyc=%0d, expected kind=%0d ch=%0d val=%0d dir=%0d cyc=%0d",
                         kind, ch, val, dv, cyc, e.kind, e.ch, e.val, e.dir, e.cyc);
            end
        end
    endtask

    // Monitor: compare every output event against the scoreboard queue.
    always @(negedge clk) begin
        if (rstn) begin
            for (int c = 0; c < N_CH; c++) begin
                if (step[c]) begin
                    steps[c]++;
                    check_evt(0, c, int'(cnt[c*CNT_W +: CNT_W]), int'(dir[c]));
                end
                if (pb_press[c]) begin
                    check_evt(1, c, int'(pb_cnt[c*PB_W +: PB_W]), 1);
                end
            end
        end
    end

    // Position of a state in the up sequence 00,10,11,01.
    function automatic int qpos(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N_CH; c++) begin
            mcnt[c] = 0;
            mpb[c]  = 0;
        end
    endtask

    task automatic model_move(input int ch, input logic [1:0] cur, input int ecyc, input bit wclr);
        int   d;
        bit   cnt_it;
        bit   up;
        exp_t e;
        d      = (qpos(cur) - qpos(mab[ch])) & 3;
        up     = (d == 1);
        cnt_it = 1'b0;
        if (d == 1 || d == 3) begin
            if (mode == 2'b00)      cnt_it = !mab[ch][1] && cur[1];
            else if (mode == 2'b01) cnt_it = (mab[ch][1] != cur[1]);
            else                    cnt_it = 1'b1;
        end
        mab[ch] = cur;
        if (cnt_it) begin
            if (up) begin
                if (mcnt[ch] == MAXC) mcnt[ch] = sat ? MAXC : 0;
                else                  mcnt[ch] = mcnt[ch] + 1;
            end else begin
                if (mcnt[ch] == 0)    mcnt[ch] = sat ? 0 : MAXC;
                else                  mcnt[ch] = mcnt[ch] - 1;
            end
        end
        if (wclr) model_clear();
        if (cnt_it) begin
            e.kind = 0; e.ch = ch; e.val = mcnt[ch]; e.dir = up ? 1 : 0; e.cyc = ecyc;
            q.push_back(e);
        end
    endtask

    // Change one channel's phases; optionally pulse clr on the update edge.
    task automatic move(input int ch, input logic a, input logic b, input bit wclr);
        int p;
        @(posedge clk); #1;
        A[ch] = a;
        B[ch] = b;
        p = cyc;
        model_move(ch, {a, b}, p + LAT, wclr);
        if (wclr) begin
            repeat (LAT - 1) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
            repeat (5) @(posedge clk);
        end else begin
            repeat (11) @(posedge clk);
        end
    endtask

    task automatic do_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic s);
        @(posedge clk); #1;
        mode = m;
        sat  = s;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int   s0;
        int   p;
        exp_t e;

        for (int c = 0; c < N_CH; c++) begin
            steps[c] = 0;
            mab[c]   = 2'b00;
        end
        model_clear();
        rstn = 1'b0; A = '0; B = '0; PB = '0; mode = 2'b10; sat = 1'b0; clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_pb_cnt", 32'(pb_cnt), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_press", 32'(pb_press), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rstn = 1'b1;
        repeat (10) @(posedge clk);

        // x4 wrap, 8 clean up-cycles on ch0
        s0 = steps[0];
        repeat (8) begin
            move(0, 1'b1, 1'b0, 1'b0);
            move(0, 1'b1, 1'b1, 1'b0);
            move(0, 1'b0, 1'b1, 1'b0);
            move(0, 1'b0, 1'b0, 1'b0);
        end
        chk("x4_cnt0", 32'(cnt[7:0]), 32'd32);
        chk("x4_dir0", 32'(dir[0]), 32'd1);
        chk("x4_steps0", 32'(steps[0] - s0), 32'd32);

        // x1 down-cycle wraps 0 -> 255
        do_clr();
        chk("clr_cnt0", 32'(cnt[7:0]), 32'd0);
        set_mode(2'b00, 1'b0);
        move(0, 1'b0, 1'b1, 1'b0);
        move(0, 1'b1, 1'b1, 1'b0);
        move(0, 1'b1, 1'b0, 1'b0);
        move(0, 1'b0, 1'b0, 1'b0);
        chk("x1_wrap_cnt0", 32'(cnt[7:0]), 32'd255);
        chk("x1_wrap_dir0", 32'(dir[0]), 32'd0);

        // x1 saturate: up to 1, down to 0, down clamped at 0
        set_mode(2'b00, 1'b1);
        do_clr();
        move(0, 1'b1, 1'b0, 1'b0);
        move(0, 1'b1, 1'b1, 1'b0);
        move(0, 1'b0, 1'b1, 1'b0);
        move(0, 1'b0, 1'b0, 1'b0);
        chk("x1_up_cnt0", 32'(cnt[7:0]), 32'd1);
        chk("x1_up_dir0", 32'(dir[0]), 32'd1);
        repeat (2) begin
            move(0, 1'b0, 1'b1, 1'b0);
            move(0, 1'b1, 1'b1, 1'b0);
            move(0, 1'b1, 1'b0, 1'b0);
            move(0, 1'b0, 1'b0, 1'b0);
        end
        chk("x1_sat_cnt0", 32'(cnt[7:0]), 32'd0);
        chk("x1_sat_dir0", 32'(dir[0]), 32'd0);

        // x2: one up-cycle counts two
        set_mode(2'b01, 1'b0);
        move(0, 1'b1, 1'b0, 1'b0);
        move(0, 1'b1, 1'b1, 1'b0);
        move(0, 1'b0, 1'b1, 1'b0);
        move(0, 1'b0, 1'b0, 1'b0);
        chk("x2_cnt0", 32'(cnt[7:0]), 32'd2);

        // Simultaneous events on both channels (mode 11 acts as x4)
        set_mode(2'b11, 1'b0);
        @(posedge clk); #1;
        A = 2'b11;
        p = cyc;
        model_move(0, 2'b10, p + LAT, 1'b0);
        model_move(1, 2'b10, p + LAT, 1'b0);
        repeat (11) @(posedge clk);
        chk("sim_cnt", 32'(cnt), 32'h0103);
        @(posedge clk); #1;
        A = 2'b00;
        p = cyc;
        model_move(0, 2'b00, p + LAT, 1'b0);
        model_move(1, 2'b00, p + LAT, 1'b0);
        repeat (11) @(posedge clk);
        chk("sim_back_cnt", 32'(cnt), 32'h0002);

        // Illegal double transition on ch0
        move(0, 1'b1, 1'b1, 1'b0);
        chk("ill_cnt0", 32'(cnt[7:0]), 32'd2);
        chk("ill_err", 32'(err), 32'h1);
        do_clr();
        chk("ill_clr_err", 32'(err), 32'h0);
        chk("ill_clr_cnt0", 32'(cnt[7:0]), 32'd0);
        move(0, 1'b0, 1'b1, 1'b0);
        move(0, 1'b0, 1'b0, 1'b0);
        chk("legal_after_cnt0", 32'(cnt[7:0]), 32'd2);

        // PB on ch1: two 3-clock glitches, then 20 clocks stable high
        repeat (2) begin
            @(posedge clk); #1 PB[1] = 1'b1;
            repeat (3) @(posedge clk);
            #1 PB[1] = 1'b0;
            repeat (3) @(posedge clk);
        end
        @(posedge clk); #1 PB[1] = 1'b1;
        p = cyc;
        e.kind = 1; e.ch = 1; e.val = mpb[1] + 1; e.dir = 1; e.cyc = p + LAT;
        mpb[1] = mpb[1] + 1;
        q.push_back(e);
        repeat (20) @(posedge clk);
        #1 PB[1] = 1'b0;
        repeat (12) @(posedge clk);
        chk("pb_cnt1", 32'(pb_cnt[23:12]), 32'd1);
        chk("pb_cnt0", 32'(pb_cnt[11:0]), 32'd0);
        chk("pb_ch0_cnt0", 32'(cnt[7:0]), 32'd2);

        // Reset mid-debounce, pins high at release
        @(posedge clk); #1 A[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        A = 2'b11; B = 2'b11; PB = 2'b11;
        #1;
        chk("mid_rst_cnt", 32'(cnt), 32'h0);
        chk("mid_rst_step", 32'(step), 32'h0);
        model_clear();
        for (int c = 0; c < N_CH; c++) mab[c] = 2'b11;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (12) @(posedge clk);
        chk("arm_cnt", 32'(cnt), 32'h0);
        chk("arm_pb_cnt", 32'(pb_cnt), 32'h0);
        chk("arm_err", 32'(err), 32'h0);

        // Step on ch0 up to 1, then clr coincident with the next step
        move(0, 1'b0, 1'b1, 1'b0);
        chk("pre_clr_cnt0", 32'(cnt[7:0]), 32'd1);
        move(0, 1'b0, 1'b0, 1'b1);
        chk("clr_step_cnt0", 32'(cnt[7:0]), 32'd0);
        chk("clr_step_dir0", 32'(dir[0]), 32'd1);

        // Drain the scoreboard within a bounded window
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
